// File: rtl/mac_sched_pkg.sv
// Shared constants for the mac_sched round-robin MAC scheduler.
// The MAC_SCHED_BEATCNT_EN build option uses BEAT_W and beat_sat_inc.
package mac_sched_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 10;
    localparam int NREQ   = 2;
    localparam int BEAT_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    function automatic logic [BEAT_W-1:0] beat_sat_inc(input logic [BEAT_W-1:0] v);
        return (v == {BEAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mac_rr_arb.sv
// Two-way round-robin grant: the priority holder wins if valid, otherwise the other requester.
module mac_rr_arb
    import mac_sched_pkg::*;
(
    input  logic [NREQ-1:0] req_valid,
    input  logic            prio,
    output logic            grant,
    output logic            any_req
);

    assign any_req = |req_valid;
    assign grant   = req_valid[prio] ? prio : ~prio;

endmodule

// File: rtl/mac_sched.sv
// Shares one external accumulate-every-cycle MAC between two job-streaming requesters.
// Build option MAC_SCHED_BEATCNT_EN adds rsp_beats (accepted quads per job, saturating).
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*DW-1:0] req_c,
    input  logic [NREQ*DW-1:0] req_d,
    output logic [DW-1:0]      mac_a,
    output logic [DW-1:0]      mac_b,
    output logic [DW-1:0]      mac_c,
    output logic [DW-1:0]      mac_d,
    output logic               mac_rst,
    input  logic [AW-1:0]      mac_acc,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [AW-1:0]      rsp_data,
`ifdef MAC_SCHED_BEATCNT_EN
    output logic [BEAT_W-1:0]  rsp_beats,
`endif
    output logic               rsp_id,
    output logic [2:0]         state_o
);

    // Handshakes: a quad transfers on a cycle where req_valid[i] && req_ready[i];
    // a result transfers on a cycle where rsp_valid && rsp_ready. Producers hold
    // their payload stable while valid is high and not yet accepted.

    logic [2:0]    state_q, state_d;
    logic          g_q, g_d;
    logic          prio_q, prio_d;
    logic [AW-1:0] rsp_data_q;
    logic          arb_grant;
    logic          arb_any;
    logic          beat_fire;

    mac_rr_arb u_arb (
        .req_valid (req_valid),
        .prio      (prio_q),
        .grant     (arb_grant),
        .any_req   (arb_any)
    );

    assign beat_fire = (state_q == ST_RUN) && req_valid[g_q];

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    g_d     = arb_grant;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (beat_fire && req_last[g_q]) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    prio_d  = ~g_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            g_q        <= 1'b0;
            prio_q     <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            prio_q  <= prio_d;
            // The final beat has landed in the accumulator by the end of DRAIN.
            if (state_q == ST_DRAIN) rsp_data_q <= mac_acc;
        end
    end

`ifdef MAC_SCHED_BEATCNT_EN
    logic [BEAT_W-1:0] beats_q;

    always_ff @(posedge clk) begin
        if (rst || state_q == ST_CLEAR) begin
            beats_q <= '0;
        end else if (beat_fire) begin
            beats_q <= beat_sat_inc(beats_q);
        end
    end

    assign rsp_beats = beats_q;
`endif

    // Non-beat cycles must feed zeros because the MAC accumulates unconditionally.
    assign mac_a = beat_fire ? req_a[g_q*DW +: DW] : '0;
    assign mac_b = beat_fire ? req_b[g_q*DW +: DW] : '0;
    assign mac_c = beat_fire ? req_c[g_q*DW +: DW] : '0;
    assign mac_d = beat_fire ? req_d[g_q*DW +: DW] : '0;

    assign req_ready = (state_q == ST_RUN) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    assign mac_rst   = rst || (state_q == ST_CLEAR);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = g_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched with a behavioural accumulate-every-cycle MAC on the operand ports.
module tb_mac_sched;
    import mac_sched_pkg::*;

    localparam int DW = 4;
    localparam int AW = 10;
    localparam int EW = 1 + BEAT_W + AW;

    // ---------------- clock / reset / wiring ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          vld [2];
    logic          lst [2];
    logic [DW-1:0] oa [2], ob [2], oc [2], od [2];

    logic [1:0]      req_valid, req_ready, req_last;
    logic [2*DW-1:0] req_a, req_b, req_c, req_d;
    logic [DW-1:0]   mac_a, mac_b, mac_c, mac_d;
    logic            mac_rst;
    logic [AW-1:0]   mac_acc;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [AW-1:0]   rsp_data;
    logic [2:0]      state_o;
`ifdef MAC_SCHED_BEATCNT_EN
    logic [BEAT_W-1:0] rsp_beats;
`endif

    assign req_valid = {vld[1], vld[0]};
    assign req_last  = {lst[1], lst[0]};
    assign req_a     = {oa[1], oa[0]};
    assign req_b     = {ob[1], ob[0]};
    assign req_c     = {oc[1], oc[0]};
    assign req_d     = {od[1], od[0]};

    mac_sched #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_last  (req_last),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_d     (req_d),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_d     (mac_d),
        .mac_rst   (mac_rst),
        .mac_acc   (mac_acc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef MAC_SCHED_BEATCNT_EN
        .rsp_beats (rsp_beats),
`endif
        .rsp_id    (rsp_id),
        .state_o   (state_o)
    );

    // Stand-in for the shared MAC: acc += A*B + C*D every clock, cleared by rst.
    always @(posedge clk) begin
        if (mac_rst) mac_acc <= '0;
        else mac_acc <= mac_acc + AW'(mac_a * mac_b) + AW'(mac_c * mac_d);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int n_checks = 0;
    int n_errors = 0;
    int last_acc_cyc = -100;
    logic prev_rsp_valid = 1'b0;
    int w0, w1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [BEAT_W-1:0] beats, input logic [AW-1:0] data);
        exp_q.push_back({id, beats, data});
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input logic [DW-1:0] d,
                             input logic last, output int waited);
        oa[id] = a; ob[id] = b; oc[id] = c; od[id] = d;
        lst[id] = last;
        vld[id] = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (req_ready[id]) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL ready_timeout: requester %0d waited %0d cycles, required at most 200", id, waited);
                break;
            end
        end
        if (last) last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        vld[id] = 1'b0;
        lst[id] = 1'b0;
        oa[id] = '0; ob[id] = '0; oc[id] = '0; od[id] = '0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
        idle_cycles(2);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && !prev_rsp_valid) chk("rsp_latency", cyc - last_acc_cyc, 2);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got data %0d id %0d, expected no response", rsp_data, rsp_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, mon_e[AW-1:0]);
                    chk("rsp_id", rsp_id, mon_e[EW-1]);
`ifdef MAC_SCHED_BEATCNT_EN
                    chk("rsp_beats", rsp_beats, mon_e[AW +: BEAT_W]);
`endif
                end
            end
        end
        prev_rsp_valid = rsp_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; lst[i] = 1'b0;
            oa[i] = '0; ob[i] = '0; oc[i] = '0; od[i] = '0;
        end
        rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", state_o, ST_IDLE);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_mac_rst", mac_rst, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_mac_ops", {mac_a, mac_b, mac_c, mac_d}, 0);
`ifdef MAC_SCHED_BEATCNT_EN
        chk("reset_rsp_beats", rsp_beats, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_mac_rst", mac_rst, 0);
        idle_cycles(1);

        // Two-beat job on requester 0: 12 + 36.
        push_exp(1'b0, 8'd2, 10'd48);
        send_beat(0, 4'd5, 4'd2, 4'd2, 4'd1, 1'b0, w0);
        chk("first_beat_latency", w0, 2);
        send_beat(0, 4'd3, 4'd2, 4'd5, 4'd6, 1'b1, w0);
        wait_drain();

        // Requester 1 with bubbles between beats: 16 + 7.
        push_exp(1'b1, 8'd2, 10'd23);
        send_beat(1, 4'd4, 4'd4, 4'd0, 4'd0, 1'b0, w1);
        idle_cycles(3);
        send_beat(1, 4'd2, 4'd3, 4'd1, 4'd1, 1'b1, w1);
        wait_drain();

        // Contention with prio=0 after requester 1's job.
        push_exp(1'b0, 8'd1, 10'd35);
        push_exp(1'b1, 8'd1, 10'd2);
        fork
            send_beat(0, 4'd5, 4'd6, 4'd1, 4'd5, 1'b1, w0);
            send_beat(1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1, w1);
        join
        wait_drain();

        // Wrap: 3 * 450 = 1350 -> 326.
        push_exp(1'b0, 8'd3, 10'd326);
        send_beat(0, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0, w0);
        send_beat(0, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0, w0);
        send_beat(0, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1, w0);
        wait_drain();

        // Contention with prio=1 after requester 0's job: id1 first.
        push_exp(1'b1, 8'd1, 10'd2);
        push_exp(1'b0, 8'd1, 10'd35);
        fork
            send_beat(0, 4'd5, 4'd6, 4'd1, 4'd5, 1'b1, w0);
            send_beat(1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1, w1);
        join
        wait_drain();

        // Abort mid-job with rst; the partial sum must not leak into the next job.
        send_beat(0, 4'd3, 4'd3, 4'd3, 4'd3, 1'b0, w0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mac_rst", mac_rst, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_state", state_o, ST_IDLE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        idle_cycles(1);
        // prio was 1 before the abort; reset returns it to 0 so id0 wins.
        push_exp(1'b0, 8'd1, 10'd14);
        push_exp(1'b1, 8'd1, 10'd2);
        fork
            send_beat(0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, w0);
            send_beat(1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1, w1);
        join
        wait_drain();

        // Response backpressure while requester 1 waits.
        rsp_ready = 1'b0;
        push_exp(1'b0, 8'd3, 10'd6);
        push_exp(1'b1, 8'd1, 10'd4);
        fork
            begin
                send_beat(0, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0, w0);
                send_beat(0, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0, w0);
                send_beat(0, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1, w0);
            end
            send_beat(1, 4'd2, 4'd2, 4'd0, 4'd0, 1'b1, w1);
            begin : hold_blk
                int t;
                t = 0;
                while (!rsp_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_rsp_arrived", rsp_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_rsp_valid", rsp_valid, 1);
                    chk("bp_rsp_data", rsp_data, 6);
                    chk("bp_rsp_id", rsp_id, 0);
                    chk("bp_req_ready", req_ready, 0);
`ifdef MAC_SCHED_BEATCNT_EN
                    chk("bp_rsp_beats", rsp_beats, 3);
`endif
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        wait_drain();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
